// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment encodings and scheduler state type for the seven-segment scanner
package seg_pkg;

  // {a,b,c,d,e,f,g,dp}, active-high
  localparam logic [7:0] SEG_0     = 8'b11111100;
  localparam logic [7:0] SEG_1     = 8'b01100000;
  localparam logic [7:0] SEG_2     = 8'b11011010;
  localparam logic [7:0] SEG_3     = 8'b11110010;
  localparam logic [7:0] SEG_4     = 8'b01100110;
  localparam logic [7:0] SEG_5     = 8'b10110110;
  localparam logic [7:0] SEG_6     = 8'b10111110;
  localparam logic [7:0] SEG_7     = 8'b11100000;
  localparam logic [7:0] SEG_8     = 8'b11111110;
  localparam logic [7:0] SEG_9     = 8'b11110110;
  localparam logic [7:0] SEG_DASH  = 8'b00000010;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {S_BLANK, S_SCAN} scan_state_t;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational BCD nibble + dp + suppress to segment pattern
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       suppress,
  output logic [7:0] seg
);

  always_comb begin
    unique case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hF:    seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
    if (suppress) seg = SEG_BLANK;
    // dp survives suppression so a blanked leading digit can still carry a point
    seg[0] = dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered MSD-first digit scan scheduler with inter-digit blanking
// Optional LEADING_ZERO_BLANK_EN: blank zero digits above the most-significant nonzero digit.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [7:0]              digit_seg,
  output logic                    frame_tick
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_digits, staging_digits, src_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp, staging_dp, src_dp;
  logic [NUM_DIGITS-1:0]   sup;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic                    frame_start;
  logic [3:0]              cur_nibble;
  logic                    cur_dp, cur_sup;
  logic [7:0]              dec_seg;

  assign load_ready = ~pending;
  assign sel_next   = NUM_DIGITS'(1) << idx;

  // On the frame-start edge the first digit must already reflect the staged value
  always_comb begin
    frame_start = (state == S_BLANK) && (cnt == BLANK_LAST) && (idx == IDX_LAST);
    src_digits  = (frame_start && pending) ? staging_digits : shadow_digits;
    src_dp      = (frame_start && pending) ? staging_dp : shadow_dp;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;
  always_comb begin
    lead_zero = 1'b1;
    sup       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero & (src_digits[4*i +: 4] == 4'h0);
      if (i != 0) sup[i] = lead_zero;
    end
  end
`else
  assign sup = '0;
`endif

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_sup    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = src_digits[4*i +: 4];
        cur_dp     = src_dp[i];
        cur_sup    = sup[i];
      end
    end
  end

  seg_decode u_decode (
    .nibble   (cur_nibble),
    .dp       (cur_dp),
    .suppress (cur_sup),
    .seg      (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state          <= S_BLANK;
      idx            <= IDX_LAST;
      cnt            <= '0;
      digit_sel      <= '0;
      digit_seg      <= SEG_BLANK;
      frame_tick     <= 1'b0;
      shadow_digits  <= '0;
      shadow_dp      <= '0;
      staging_digits <= '0;
      staging_dp     <= '0;
      pending        <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (load_valid && !pending) begin
        staging_digits <= digits_in;
        staging_dp     <= dp_in;
        pending        <= 1'b1;
      end
      unique case (state)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state     <= S_SCAN;
            cnt       <= '0;
            digit_sel <= sel_next;
            digit_seg <= dec_seg;
            if (frame_start) begin
              frame_tick <= 1'b1;
              if (pending) begin
                shadow_digits <= staging_digits;
                shadow_dp     <= staging_dp;
                pending       <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SCAN: begin
          if (cnt == DWELL_LAST) begin
            state     <= S_BLANK;
            cnt       <= '0;
            digit_sel <= '0;
            digit_seg <= SEG_BLANK;
            idx       <= (idx == '0) ? IDX_LAST : idx - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench: frame-level reference model vs scanned digit outputs
module tb_seg_scan_ctrl;

  localparam int N = 2;
  localparam int D = 8;
  localparam int B = 2;
  localparam int F = N * (D + B);

  logic         clk = 1'b0;
  logic         res;
  logic         load_valid;
  logic         load_ready;
  logic [7:0]   digits_in;
  logic [1:0]   dp_in;
  logic [1:0]   digit_sel;
  logic [7:0]   digit_seg;
  logic         frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .res        (res),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_sel  (digit_sel),
    .digit_seg  (digit_seg),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] seg;
    logic       tick;
  } scan_t;

  scan_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00};

  logic [7:0] m_shadow, m_stage;
  logic [1:0] m_shadow_dp, m_stage_dp;
  logic       m_pending;
  int         t;
  logic       acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [7:0] digs, input logic [1:0] dps, input int i);
    int v;
    logic [7:0] p;
    v = int'(digs) >> (4 * i);
    p = SEG_TBL[v % 16];
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && v == 0) p = 8'h00;
`endif
    if (dps[i]) p = p | 8'h01;
    return p;
  endfunction

  // True when the DUT will still be driving a digit across the next edge
  function automatic bit scan_next();
    int off;
    if (t < B) return 1'b0;
    off = ((t - B) % F) % (D + B);
    return off < D - 1;
  endfunction

  task automatic step();
    logic r, a;
    scan_t e;
    @(posedge clk);
    r = res;
    a = load_valid && !m_pending && !r;
    #1;
    if (r) begin
      m_pending = 1'b0; m_stage = '0; m_stage_dp = '0;
      m_shadow = '0; m_shadow_dp = '0; t = 0;
    end else begin
      t++;
      if (t >= B && (t - B) % F == 0) begin
        if (m_pending) begin
          m_shadow = m_stage; m_shadow_dp = m_stage_dp; m_pending = 1'b0;
        end
        for (int i = N - 1; i >= 0; i--) begin
          e.sel  = 2'(1 << i);
          e.seg  = exp_seg(m_shadow, m_shadow_dp, i);
          e.tick = (i == N - 1);
          sb_q.push_back(e);
        end
      end
      if (a) begin
        m_stage = digits_in; m_stage_dp = dp_in; m_pending = 1'b1;
      end
    end
    acc = a;
    check("load_ready", 32'(load_ready), 32'(!m_pending));
  endtask

  task automatic load(input logic [7:0] d, input logic [1:0] p);
    int k;
    digits_in = d; dp_in = p; load_valid = 1'b1;
    for (k = 0; k < 4 * F; k++) begin
      step();
      if (acc) break;
    end
    load_valid = 1'b0;
    check("load_accept", 32'(k < 4 * F), 32'd1);
  endtask

  // Monitor: pops one expectation at each digit turn-on, checks hold and blank timing
  logic       res_q;
  logic [1:0] prev_sel;
  logic [7:0] prev_seg;
  int         blank_run, on_run;
  scan_t      got;

  initial begin
    prev_sel = '0; prev_seg = '0; blank_run = 0; on_run = 0;
    forever begin
      @(posedge clk);
      res_q = res;
      @(negedge clk);
      if (res_q) begin
        sb_q.delete();
        check("rst_sel", 32'(digit_sel), 32'd0);
        check("rst_seg", 32'(digit_seg), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        blank_run = 1; on_run = 0;
      end else if (digit_sel != 2'b00) begin
        if (prev_sel == 2'b00) begin
          check("blank_len", blank_run, B);
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check("scan_sel", 32'(digit_sel), 32'(got.sel));
            check("scan_seg", 32'(digit_seg), 32'(got.seg));
            check("frame_tick", 32'(frame_tick), 32'(got.tick));
          end
          on_run = 1; blank_run = 0;
        end else begin
          on_run++;
          check("hold_sel", 32'(digit_sel), 32'(prev_sel));
          check("hold_seg", 32'(digit_seg), 32'(prev_seg));
          check("tick_idle", 32'(frame_tick), 32'd0);
        end
      end else begin
        if (prev_sel != 2'b00) begin
          check("dwell_len", on_run, D);
          blank_run = 0;
        end
        blank_run++;
        check("blank_seg", 32'(digit_seg), 32'd0);
        check("tick_idle", 32'(frame_tick), 32'd0);
      end
      prev_sel = res_q ? 2'b00 : digit_sel;
      prev_seg = digit_seg;
    end
  end

  initial begin
    bit found;
    res = 1'b1; load_valid = 1'b0; digits_in = '0; dp_in = '0;
    m_shadow = '0; m_stage = '0; m_shadow_dp = '0; m_stage_dp = '0;
    m_pending = 1'b0; t = 0; acc = 1'b0;
    repeat (3) step();
    check("init_sel", 32'(digit_sel), 32'd0);
    check("init_seg", 32'(digit_seg), 32'd0);
    check("init_ready", 32'(load_ready), 32'd1);
    check("init_tick", 32'(frame_tick), 32'd0);
    res = 1'b0;

    load(8'h42, 2'b00);
    load(8'h13, 2'b00);
    load(8'h05, 2'b00);
    load(8'h00, 2'b00);
    load(8'hFA, 2'b01);
    repeat (2 * F) step();

    // Reset while a digit is lit and a value is still staged
    found = 1'b0;
    for (int k = 0; k < 4 * F; k++) begin
      if (!m_pending && !load_valid) begin
        digits_in = 8'($urandom); dp_in = 2'($urandom); load_valid = 1'b1;
      end
      step();
      if (acc) load_valid = 1'b0;
      if (m_pending && !load_valid && scan_next()) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_window", 32'(found), 32'd1);
    res = 1'b1;
    step();
    res = 1'b0;
    load_valid = 1'b0;
    repeat (2 * F) step();

    for (int k = 0; k < 800; k++) begin
      if (!load_valid && $urandom_range(0, 2) == 0) begin
        digits_in = 8'($urandom); dp_in = 2'($urandom); load_valid = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) res = 1'b1;
      step();
      res = 1'b0;
      if (acc) load_valid = 1'b0;
    end
    repeat (F) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
